upc_key_entry: RTL

Input-side companion to the BCD seven-segment and UPC detector datapath: it produces the 4-bit UPC/BCD code that the display decoder and the detector consume. Three active-low DE1 pushbuttons edit and commit the code. Each button passes through a synchronizer, a debouncer and a press-edge detector. A committed code is offered downstream on a valid/ready handshake.

---
 rtl/upc_key_entry_if.sv | 9 +
 rtl/upc_key_entry.sv | 95 +++++++++
 2 files changed

// File: rtl/upc_key_entry_if.sv
// Committed-code handshake between the key-entry block and its consumer.
interface upc_key_entry_if;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/upc_key_entry.sv
// Pushbutton code entry: sync + debounce + press detect on three KEYs,
// modular edit code, and a valid/ready commit port with overflow flag.
module upc_key_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_CODE        = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_inc_n,
  input  logic                   key_dec_n,
  input  logic                   key_commit_n,
  output logic [3:0]             code,
  output logic                   overflow,
  upc_key_entry_if.master        down
);

  localparam int unsigned NKEY   = 3;
  localparam int unsigned CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned KI_INC = 0;
  localparam int unsigned KI_DEC = 1;
  localparam int unsigned KI_CMT = 2;

  logic [NKEY-1:0] raw_n;
  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [NKEY-1:0] deb;
  logic [NKEY-1:0] ev;
  logic [CW-1:0]   cnt [NKEY];
  logic [3:0]      code_nxt;
  logic            accept;

  assign raw_n  = {key_commit_n, key_dec_n, key_inc_n};
  assign accept = down.out_valid & down.out_ready;

  // Synchronize, debounce and register a one-cycle pulse on each accepted press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      ev    <= '0;
      for (int i = 0; i < NKEY; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      for (int i = 0; i < NKEY; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
          // Only a released-to-pressed transition is an event.
          ev[i]  <= deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Modular edit arithmetic; coincident inc and dec cancel.
  always_comb begin
    code_nxt = code;
    if (ev[KI_INC] && !ev[KI_DEC]) begin
      code_nxt = (code == 4'(MAX_CODE)) ? 4'd0 : code + 4'd1;
    end else if (ev[KI_DEC] && !ev[KI_INC]) begin
      code_nxt = (code == 4'd0) ? 4'(MAX_CODE) : code - 4'd1;
    end
  end

  // Edit code register and commit handshake; a commit captures the pre-edit code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code           <= 4'd0;
      down.out_data  <= 4'd0;
      down.out_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      code     <= code_nxt;
      overflow <= 1'b0;
      if (ev[KI_CMT]) begin
        if (!down.out_valid || accept) begin
          down.out_data  <= code;
          down.out_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        down.out_valid <= 1'b0;
      end
    end
  end

endmodule
